// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared encodings for the PC sequencer.
// pc_op codes for the control unit, debug FSM states.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_BR   = 3'd1,
        OP_JMP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } pc_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack, overwrites oldest when full.
// Ports: clk, reset (async), clear (sync), push, pop, din -> dout, empty, full.
module pc_ras #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     wp_inc;
    logic [PW-1:0]     wp_dec;
    logic [CW-1:0]     cnt;

    // wp points at the next free slot; top of stack sits just below it
    always_comb begin
        wp_inc = (wp == PW'(RAS_DEPTH - 1)) ? '0 : wp + PW'(1);
        wp_dec = (wp == '0) ? PW'(RAS_DEPTH - 1) : wp - PW'(1);
    end

    assign dout  = mem[wp_dec];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(RAS_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp_inc;
            if (!full)
                cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            wp  <= wp_dec;
            cnt <= cnt - CW'(1);
        end
    end

    // contents need no reset: cnt governs what is valid
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wp] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/call/return and debug FSM.
// Ports: control (stall, pc_op, target), debug (dbg_*), pc/pc_next, RAS flags.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        pc_op,
    input  logic [ADDR_W-1:0] target,
    input  logic              dbg_enable,
    input  logic              dbg_step,
    input  logic              dbg_reset,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              dbg_halted
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);

    pc_state_e         state_q;
    pc_state_e         state_d;
    logic              step_prev;
    logic              step_rise;
    logic              advance;
    logic              is_call;
    logic              is_ret;
    logic              ret_miss;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_dout;
    logic              ras_empty;
    logic              ras_full;

    assign step_rise  = dbg_step & ~step_prev;
    assign dbg_halted = (state_q != ST_RUN);

    // RUN also needs dbg_enable so the edge leaving RUN does not advance
    assign advance = ((state_q == ST_RUN) & dbg_enable & ~stall) |
                     ((state_q == ST_STEP) & ~stall);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (!dbg_reset && !dbg_enable)
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!dbg_reset) begin
                    if (dbg_enable)
                        state_d = ST_RUN;
                    else if (step_rise)
                        state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (dbg_reset || !stall)
                    state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        pc_next  = pc + ADDR_W'(1);
        is_call  = 1'b0;
        is_ret   = 1'b0;
        ret_miss = 1'b0;
        case (pc_op)
            OP_BR:   pc_next = pc + target;
            OP_JMP:  pc_next = target;
            OP_CALL: begin
                pc_next = target;
                is_call = 1'b1;
            end
            OP_RET: begin
                if (ras_empty) begin
                    ret_miss = 1'b1;
                end else begin
                    pc_next = ras_dout;
                    is_ret  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ras_push = advance & is_call & ~dbg_reset;
    assign ras_pop  = advance & is_ret & ~dbg_reset;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .clear (dbg_reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc + ADDR_W'(1)),
        .dout  (ras_dout),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HALT;
            step_prev <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_prev <= dbg_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RST_PC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (dbg_reset) begin
            pc            <= RST_PC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (advance) begin
            pc <= pc_next;
            if (is_call && ras_full)
                ras_overflow <= 1'b1;
            if (ret_miss)
                ras_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus against a queue-based model.
// Checks pc, pc_next, flags and dbg_halted every cycle.
module tb_pc_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int RA    = 0;
    localparam int MASK  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic [2:0]    pc_op;
    logic [AW-1:0] target;
    logic          dbg_enable;
    logic          dbg_step;
    logic          dbg_reset;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic          ras_overflow;
    logic          ras_underflow;
    logic          dbg_halted;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_pc;
    int m_ras[$];
    bit m_ovf;
    bit m_unf;
    bit m_run;
    bit m_step;
    bit m_prev;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W     (AW),
        .RAS_DEPTH  (DEPTH),
        .RESET_ADDR (RA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_op         (pc_op),
        .target        (target),
        .dbg_enable    (dbg_enable),
        .dbg_step      (dbg_step),
        .dbg_reset     (dbg_reset),
        .pc            (pc),
        .pc_next       (pc_next),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .dbg_halted    (dbg_halted)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int model_next();
        int op = int'(pc_op);
        int t  = int'(target);
        if (op == 1) return (m_pc + t) & MASK;
        if (op == 2) return t;
        if (op == 3) return t;
        if (op == 4 && m_ras.size() > 0)
            return m_ras[m_ras.size() - 1];
        return (m_pc + 1) & MASK;
    endfunction

    task automatic model_reset();
        m_pc = RA;
        m_ras.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_run  = 0;
        m_step = 0;
        m_prev = 0;
    endtask

    task automatic model_edge();
        bit adv;
        bit rise;
        int nxt;
        adv  = (m_run && dbg_enable && !stall) ||
               (m_step && !stall);
        rise = dbg_step && !m_prev;
        nxt  = model_next();
        if (dbg_reset) begin
            m_pc = RA;
            m_ras.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_step = 0;
        end else begin
            if (adv) begin
                if (pc_op == 3'd3) begin
                    m_ras.push_back((m_pc + 1) & MASK);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                end else if (pc_op == 3'd4) begin
                    if (m_ras.size() > 0)
                        void'(m_ras.pop_back());
                    else
                        m_unf = 1;
                end
                m_pc = nxt;
            end
            if (m_run) begin
                if (!dbg_enable) m_run = 0;
            end else if (m_step) begin
                if (!stall) m_step = 0;
            end else begin
                if (dbg_enable) m_run = 1;
                else if (rise) m_step = 1;
            end
        end
        m_prev = dbg_step;
    endtask

    task automatic check_regs();
        check("pc", 32'(pc), 32'(m_pc));
        check("ovf", 32'(ras_overflow), 32'(m_ovf));
        check("unf", 32'(ras_underflow), 32'(m_unf));
        check("halted", 32'(dbg_halted), 32'(!m_run));
    endtask

    // called at posedge+1; returns at next posedge+1
    task automatic cycle();
        #2;
        check("pc_next", 32'(pc_next), 32'(model_next()));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic go(input bit en, input bit st, input bit stl,
                      input int op, input int tgt, input int n);
        dbg_enable = en;
        dbg_step   = st;
        stall      = stl;
        pc_op      = 3'(op);
        target     = AW'(tgt);
        dbg_reset  = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset();
        #3 reset = 1'b1;
        #1 model_reset();
        check_regs();
        #1 reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        pc_op      = 3'd0;
        target     = '0;
        dbg_enable = 1'b0;
        dbg_step   = 1'b0;
        dbg_reset  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check("rst_pc_next", 32'(pc_next), 32'(RA + 1));
        reset = 1'b0;

        go(1, 0, 0, 0, 0, 6);
        go(1, 0, 1, 0, 0, 3);
        go(1, 0, 0, 2, 8'h10, 1);
        go(1, 0, 0, 1, 8'hFC, 1);
        go(1, 0, 0, 2, 8'hFE, 1);
        go(1, 0, 0, 0, 0, 2);
        go(1, 0, 0, 1, 8'h03, 1);
        go(1, 0, 0, 1, 8'hF0, 1);

        go(1, 0, 0, 2, 8'h20, 1);
        go(1, 0, 0, 3, 8'h40, 1);
        go(1, 0, 0, 4, 0, 1);
        for (int i = 0; i < 5; i++)
            go(1, 0, 0, 3, 8'h50 + 16 * i, 1);
        go(1, 0, 0, 4, 0, 5);

        go(0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            go(0, 1, 0, 0, 0, 1);
            go(0, 0, 0, 0, 0, 1);
        end
        go(0, 1, 1, 0, 0, 1);
        go(0, 0, 1, 0, 0, 3);
        go(0, 0, 0, 0, 0, 2);

        go(1, 0, 0, 3, 8'h60, 1);
        go(1, 0, 0, 3, 8'h70, 1);
        go(0, 0, 0, 0, 0, 1);
        go(0, 1, 1, 0, 0, 2);
        async_reset();
        go(0, 0, 0, 0, 0, 1);
        go(1, 0, 0, 4, 0, 3);

        go(1, 0, 0, 0, 0, 4);
        dbg_reset = 1'b1;
        cycle();
        go(1, 0, 0, 0, 0, 2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4)
                dbg_enable = ~dbg_enable;
            dbg_step  = ($urandom_range(3) == 0);
            stall     = ($urandom_range(4) == 0);
            pc_op     = 3'($urandom_range(7));
            target    = AW'($urandom);
            dbg_reset = ($urandom_range(99) < 2);
            if ($urandom_range(999) < 3)
                async_reset();
            else
                cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
